// File: rtl/alu_op_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_op_pkg
// Brief  : Shared types for the RV32I ALU operation issuer. It holds the ALU
//          Operation codes, the RV32I major opcodes, the operand-source
//          selects, the funct3 constants and a shift-classification helper.
// Rev    : 1.0  initial release
// ============================================================================
package alu_op_pkg;

  // Operation codes that the issuer drives to the combinational ALU.
  typedef enum logic [3:0] {
    ALU_AND     = 4'b0000,
    ALU_OR      = 4'b0001,
    ALU_ADD     = 4'b0010,
    ALU_XOR     = 4'b0011,
    ALU_SLL     = 4'b0100,
    ALU_SRL     = 4'b0101,
    ALU_SUB     = 4'b0110,
    ALU_SRA     = 4'b0111,
    ALU_EQ      = 4'b1000,
    ALU_NE      = 4'b1001,
    ALU_GE      = 4'b1010,
    ALU_LT      = 4'b1100,
    ALU_LINK    = 4'b1101,
    ALU_ILLEGAL = 4'b1111
  } alu_op_e;

  // RV32I major opcodes, taken from instr[6:0].
  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111
  } rv_opcode_e;

  typedef enum logic [1:0] {
    SRCA_RS1  = 2'd0,
    SRCA_PC   = 2'd1,
    SRCA_ZERO = 2'd2
  } srca_sel_e;

  typedef enum logic {
    SRCB_RS2 = 1'b0,
    SRCB_IMM = 1'b1
  } srcb_sel_e;

  // funct3 values for OP / OP-IMM.
  localparam logic [2:0] c_F3_ADD  = 3'b000;
  localparam logic [2:0] c_F3_SLL  = 3'b001;
  localparam logic [2:0] c_F3_SLT  = 3'b010;
  localparam logic [2:0] c_F3_SLTU = 3'b011;
  localparam logic [2:0] c_F3_XOR  = 3'b100;
  localparam logic [2:0] c_F3_SR   = 3'b101;
  localparam logic [2:0] c_F3_OR   = 3'b110;
  localparam logic [2:0] c_F3_AND  = 3'b111;

  // funct3 values for BRANCH.
  localparam logic [2:0] c_F3_BEQ  = 3'b000;
  localparam logic [2:0] c_F3_BNE  = 3'b001;
  localparam logic [2:0] c_F3_BLT  = 3'b100;
  localparam logic [2:0] c_F3_BGE  = 3'b101;

  function automatic logic is_shift(input alu_op_e op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_issuer_encode.sv
`default_nettype none
// ============================================================================
// Module : alu_op_encode
// Brief  : Purely combinational decode of {opcode, funct3, funct7} into the
//          ALU Operation, the SrcA/SrcB source selects and the branch, link
//          and illegal flags.
// Ports  : i_opcode/i_funct3/i_funct7  instruction fields
//          o_op                        ALU Operation (ALU_ILLEGAL if illegal)
//          o_srca_sel / o_srcb_sel     operand source selects
//          o_branch / o_link           conditional branch / JAL-JALR
//          o_illegal                   unsupported combination
// Rev    : 1.0  initial release
// ============================================================================
module alu_op_encode
  import alu_op_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic [6:0] i_funct7,
  output alu_op_e    o_op,
  output srca_sel_e  o_srca_sel,
  output srcb_sel_e  o_srcb_sel,
  output logic       o_branch,
  output logic       o_link,
  output logic       o_illegal
);

  // Only funct7[5] selects between operations. The remaining bits are
  // immediate bits for OP-IMM and are deliberately ignored.
  logic w_unused_funct7;
  assign w_unused_funct7 = ^{i_funct7[6], i_funct7[4:0]};

  logic w_is_op;
  assign w_is_op = (i_opcode == OPC_OP);

  always_comb begin
    o_op       = ALU_ILLEGAL;
    o_srca_sel = SRCA_ZERO;
    o_srcb_sel = SRCB_IMM;
    o_branch   = 1'b0;
    o_link     = 1'b0;
    o_illegal  = 1'b1;
    case (i_opcode)
      OPC_OP, OPC_OP_IMM: begin
        o_srca_sel = SRCA_RS1;
        o_srcb_sel = w_is_op ? SRCB_RS2 : SRCB_IMM;
        o_illegal  = 1'b0;
        case (i_funct3)
          // SUB exists only in register form; for OP-IMM funct7 is imm bits.
          c_F3_ADD: o_op = (w_is_op && i_funct7[5]) ? ALU_SUB : ALU_ADD;
          c_F3_SLL: o_op = ALU_SLL;
          c_F3_SLT: o_op = ALU_LT;
          c_F3_XOR: o_op = ALU_XOR;
          c_F3_SR:  o_op = i_funct7[5] ? ALU_SRA : ALU_SRL;
          c_F3_OR:  o_op = ALU_OR;
          c_F3_AND: o_op = ALU_AND;
          default: begin
            // SLTU has no unsigned-compare ALU code.
            o_op      = ALU_ILLEGAL;
            o_illegal = 1'b1;
          end
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        o_op       = ALU_ADD;
        o_srca_sel = SRCA_RS1;
        o_srcb_sel = SRCB_IMM;
        o_illegal  = 1'b0;
      end
      OPC_LUI: begin
        o_op       = ALU_ADD;
        o_srca_sel = SRCA_ZERO;
        o_srcb_sel = SRCB_IMM;
        o_illegal  = 1'b0;
      end
      OPC_AUIPC: begin
        o_op       = ALU_ADD;
        o_srca_sel = SRCA_PC;
        o_srcb_sel = SRCB_IMM;
        o_illegal  = 1'b0;
      end
      OPC_BRANCH: begin
        o_srca_sel = SRCA_RS1;
        o_srcb_sel = SRCB_RS2;
        o_branch   = 1'b1;
        o_illegal  = 1'b0;
        case (i_funct3)
          c_F3_BEQ: o_op = ALU_EQ;
          c_F3_BNE: o_op = ALU_NE;
          c_F3_BLT: o_op = ALU_LT;
          c_F3_BGE: o_op = ALU_GE;
          default: begin
            o_op      = ALU_ILLEGAL;
            o_branch  = 1'b0;
            o_illegal = 1'b1;
          end
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        // The ALU result is ignored for links; pc+4 is formed by the issuer.
        o_op       = ALU_LINK;
        o_srca_sel = SRCA_PC;
        o_srcb_sel = SRCB_IMM;
        o_link     = 1'b1;
        o_illegal  = 1'b0;
      end
      default: begin
        o_op      = ALU_ILLEGAL;
        o_illegal = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_op_issuer.sv
`default_nettype none
// ============================================================================
// Module : alu_op_issuer
// Brief  : Initiator side of the RV32I ALU interface. This is a two-stage
//          pipeline. Stage D registers the decoded operation and its operands,
//          and drives the ALU. Stage E captures the ALU result together with
//          the flags for writeback.
// Ports  : in_*        valid/ready decode-side input (opcode, funct3/7, rd,
//                      rs1/rs2 data, immediate, pc)
//          alu_*       SrcA/SrcB/Operation out, ALU result in
//          out_*       valid/ready writeback side (result, rd, taken, illegal)
// Rev    : 1.0  initial release
// ============================================================================
module alu_op_issuer
  import alu_op_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               in_opcode,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [4:0]               in_rd,
  input  logic [DATA_WIDTH-1:0]    in_rs1_data,
  input  logic [DATA_WIDTH-1:0]    in_rs2_data,
  input  logic [DATA_WIDTH-1:0]    in_imm,
  input  logic [DATA_WIDTH-1:0]    in_pc,
  output logic [DATA_WIDTH-1:0]    alu_srca,
  output logic [DATA_WIDTH-1:0]    alu_srcb,
  output logic [OPCODE_LENGTH-1:0] alu_operation,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_result,
  output logic [4:0]               out_rd,
  output logic                     out_taken,
  output logic                     out_illegal
);

  // ---------------------------------------------------------------- decode
  alu_op_e   w_op;
  srca_sel_e w_srca_sel;
  srcb_sel_e w_srcb_sel;
  logic      w_branch;
  logic      w_link;
  logic      w_illegal;

  alu_op_encode u_encode (
    .i_opcode   (in_opcode),
    .i_funct3   (in_funct3),
    .i_funct7   (in_funct7),
    .o_op       (w_op),
    .o_srca_sel (w_srca_sel),
    .o_srcb_sel (w_srcb_sel),
    .o_branch   (w_branch),
    .o_link     (w_link),
    .o_illegal  (w_illegal)
  );

  logic [DATA_WIDTH-1:0] w_srca;
  logic [DATA_WIDTH-1:0] w_srcb;

  always_comb begin
    w_srca = '0;
    case (w_srca_sel)
      SRCA_RS1: w_srca = in_rs1_data;
      SRCA_PC:  w_srca = in_pc;
      default:  w_srca = '0;
    endcase
    w_srcb = (w_srcb_sel == SRCB_RS2) ? in_rs2_data : in_imm;
    // The ALU sees only a legal shift amount. Any immediate funct7 bits are stripped.
    if (is_shift(w_op)) begin
      w_srcb = {{(DATA_WIDTH-5){1'b0}}, w_srcb[4:0]};
    end
    if (w_illegal) begin
      w_srca = '0;
      w_srcb = '0;
    end
  end

  // ------------------------------------------------------------ ready chain
  logic r_d_valid;
  logic r_e_valid;
  logic w_e_ready;
  logic w_accept;
  logic w_d_fire;

  assign w_e_ready = !r_e_valid || out_ready;
  assign in_ready  = !r_d_valid || w_e_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_d_fire  = r_d_valid && w_e_ready;

  // ---------------------------------------------------------------- stage D
  logic [DATA_WIDTH-1:0] r_d_srca;
  logic [DATA_WIDTH-1:0] r_d_srcb;
  logic [DATA_WIDTH-1:0] r_d_pc;
  alu_op_e               r_d_op;
  logic [4:0]            r_d_rd;
  logic                  r_d_branch;
  logic                  r_d_link;
  logic                  r_d_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_valid   <= 1'b0;
      r_d_srca    <= '0;
      r_d_srcb    <= '0;
      r_d_pc      <= '0;
      r_d_op      <= ALU_AND;
      r_d_rd      <= '0;
      r_d_branch  <= 1'b0;
      r_d_link    <= 1'b0;
      r_d_illegal <= 1'b0;
    end else if (w_accept) begin
      // The accept takes priority. If D also fires this cycle, the new op replaces it.
      r_d_valid   <= 1'b1;
      r_d_srca    <= w_srca;
      r_d_srcb    <= w_srcb;
      r_d_pc      <= in_pc;
      r_d_op      <= w_op;
      r_d_rd      <= in_rd;
      r_d_branch  <= w_branch;
      r_d_link    <= w_link;
      r_d_illegal <= w_illegal;
    end else if (w_d_fire) begin
      r_d_valid   <= 1'b0;
    end
  end

  assign alu_srca      = r_d_srca;
  assign alu_srcb      = r_d_srcb;
  assign alu_operation = r_d_op;

  // ---------------------------------------------------------------- stage E
  logic [DATA_WIDTH-1:0] w_e_result;
  logic                  w_e_taken;

  always_comb begin
    w_e_result = alu_result;
    w_e_taken  = 1'b0;
    if (r_d_illegal) begin
      w_e_result = '0;
    end else if (r_d_link) begin
      w_e_result = r_d_pc + DATA_WIDTH'(4);
      w_e_taken  = 1'b1;
    end else if (r_d_branch) begin
      w_e_taken  = alu_result[0];
    end
  end

  logic [DATA_WIDTH-1:0] r_e_result;
  logic [4:0]            r_e_rd;
  logic                  r_e_taken;
  logic                  r_e_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_valid   <= 1'b0;
      r_e_result  <= '0;
      r_e_rd      <= '0;
      r_e_taken   <= 1'b0;
      r_e_illegal <= 1'b0;
    end else if (w_d_fire) begin
      r_e_valid   <= 1'b1;
      r_e_result  <= w_e_result;
      r_e_rd      <= r_d_rd;
      r_e_taken   <= w_e_taken;
      r_e_illegal <= r_d_illegal;
    end else if (out_ready) begin
      r_e_valid   <= 1'b0;
    end
  end

  assign out_valid   = r_e_valid;
  assign out_result  = r_e_result;
  assign out_rd      = r_e_rd;
  assign out_taken   = r_e_taken;
  assign out_illegal = r_e_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_issuer.sv
`default_nettype none
// ============================================================================
// Module : tb_alu_op_issuer
// Brief  : Directed bench for alu_op_issuer with a behavioural RV32I ALU
//          attached to the alu_* interface.
// Rev    : 1.0  initial release
// ============================================================================
module tb_alu_op_issuer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic [31:0] in_pc;
  logic [31:0] alu_srca;
  logic [31:0] alu_srcb;
  logic [3:0]  alu_operation;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_taken;
  logic        out_illegal;

  int n_err = 0;
  int n_chk = 0;

  alu_op_issuer #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_funct3     (in_funct3),
    .in_funct7     (in_funct7),
    .in_rd         (in_rd),
    .in_rs1_data   (in_rs1_data),
    .in_rs2_data   (in_rs2_data),
    .in_imm        (in_imm),
    .in_pc         (in_pc),
    .alu_srca      (alu_srca),
    .alu_srcb      (alu_srcb),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_rd        (out_rd),
    .out_taken     (out_taken),
    .out_illegal   (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU.
  always_comb begin
    alu_result = 32'h0;
    case (alu_operation)
      4'b0000: alu_result = alu_srca & alu_srcb;
      4'b0001: alu_result = alu_srca | alu_srcb;
      4'b0010: alu_result = alu_srca + alu_srcb;
      4'b0011: alu_result = alu_srca ^ alu_srcb;
      4'b0100: alu_result = alu_srca << alu_srcb[4:0];
      4'b0101: alu_result = alu_srca >> alu_srcb[4:0];
      4'b0110: alu_result = alu_srca - alu_srcb;
      4'b0111: alu_result = $unsigned($signed(alu_srca) >>> alu_srcb[4:0]);
      4'b1000: alu_result = {31'h0, alu_srca == alu_srcb};
      4'b1001: alu_result = {31'h0, alu_srca != alu_srcb};
      4'b1010: alu_result = {31'h0, $signed(alu_srca) >= $signed(alu_srcb)};
      4'b1100: alu_result = {31'h0, $signed(alu_srca) < $signed(alu_srcb)};
      default: alu_result = 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic [31:0] pc);
    in_valid    = 1'b1;
    in_opcode   = opc;
    in_funct3   = f3;
    in_funct7   = f7;
    in_rd       = rd;
    in_rs1_data = a;
    in_rs2_data = b;
    in_imm      = imm;
    in_pc       = pc;
  endtask

  // Advance to the next falling edge through one rising edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LUI    = 7'b0110111;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_in_ready",  {31'h0, in_ready}, 32'h1);
    check("reset_out_valid", {31'h0, out_valid}, 32'h0);
    check("reset_alu_op",    {28'h0, alu_operation}, 32'h0);
    check("reset_srca",      alu_srca, 32'h0);
    rst_n = 1'b1;
    step();
    // in_* are still X here but nothing was accepted.
    check("idle_no_x_result", out_result, 32'h0);
    check("idle_no_x_srcb",   alu_srcb, 32'h0);

    // ADD 5+7: Operation after one cycle, result after two.
    set_op(OP, 3'b000, 7'b0000000, 5'd3, 32'd5, 32'd7, 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    check("add_alu_op",    {28'h0, alu_operation}, 32'h2);
    check("add_srca",      alu_srca, 32'd5);
    check("add_srcb",      alu_srcb, 32'd7);
    check("add_not_yet",   {31'h0, out_valid}, 32'h0);
    step();
    check("add_out_valid", {31'h0, out_valid}, 32'h1);
    check("add_result",    out_result, 32'd12);
    check("add_rd",        {27'h0, out_rd}, 32'd3);
    check("add_taken",     {31'h0, out_taken}, 32'h0);
    step();
    check("add_drained",   {31'h0, out_valid}, 32'h0);

    // SUB then SRAI back-to-back.
    set_op(OP, 3'b000, 7'b0100000, 5'd4, 32'd3, 32'd5, 32'h0, 32'h0);
    step();
    check("sub_alu_op", {28'h0, alu_operation}, 32'h6);
    set_op(OPIMM, 3'b101, 7'b0100001, 5'd5, 32'h8000_0000, 32'h0, 32'h0000_0424, 32'h0);
    step();
    in_valid = 1'b0;
    check("sub_result",  out_result, 32'hFFFF_FFFE);
    check("srai_srcb",   alu_srcb, 32'd4);
    check("srai_alu_op", {28'h0, alu_operation}, 32'h7);
    step();
    check("srai_valid",  {31'h0, out_valid}, 32'h1);
    check("srai_result", out_result, 32'hF800_0000);
    check("srai_rd",     {27'h0, out_rd}, 32'd5);

    // BLT / BGE with -1 vs 1.
    set_op(BRANCH, 3'b100, 7'b0, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
    step();
    set_op(BRANCH, 3'b101, 7'b0, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    check("blt_taken",  {31'h0, out_taken}, 32'h1);
    check("blt_result", out_result, 32'h1);
    step();
    check("bge_valid",  {31'h0, out_valid}, 32'h1);
    check("bge_taken",  {31'h0, out_taken}, 32'h0);

    // JAL links, including pc wrap.
    set_op(JAL, 3'b000, 7'b0, 5'd1, 32'h0, 32'h0, 32'h0000_0010, 32'h0000_0100);
    step();
    set_op(JAL, 3'b000, 7'b0, 5'd1, 32'h0, 32'h0, 32'h0000_0010, 32'hFFFF_FFFC);
    step();
    in_valid = 1'b0;
    check("jal_result",      out_result, 32'h0000_0104);
    check("jal_taken",       {31'h0, out_taken}, 32'h1);
    step();
    check("jal_wrap_result", out_result, 32'h0);
    check("jal_wrap_taken",  {31'h0, out_taken}, 32'h1);

    // LUI passes the immediate through.
    set_op(LUI, 3'b000, 7'b0, 5'd6, 32'hDEAD_BEEF, 32'h0, 32'h1234_5000, 32'h0);
    step();
    in_valid = 1'b0;
    step();
    check("lui_result", out_result, 32'h1234_5000);

    // Illegal cases: bad opcode, SLTU and branch funct3 010.
    set_op(7'b1111111, 3'b000, 7'b0, 5'd7, 32'd9, 32'd9, 32'd9, 32'd9);
    step();
    check("ill_alu_op", {28'h0, alu_operation}, 32'hF);
    set_op(OP, 3'b011, 7'b0, 5'd8, 32'd1, 32'd2, 32'h0, 32'h0);
    step();
    set_op(BRANCH, 3'b010, 7'b0, 5'd0, 32'd1, 32'd1, 32'h0, 32'h0);
    check("ill_illegal", {31'h0, out_illegal}, 32'h1);
    check("ill_result",  out_result, 32'h0);
    check("ill_taken",   {31'h0, out_taken}, 32'h0);
    step();
    in_valid = 1'b0;
    check("sltu_illegal", {31'h0, out_illegal}, 32'h1);
    step();
    check("bfunct_illegal", {31'h0, out_illegal}, 32'h1);
    check("bfunct_taken",   {31'h0, out_taken}, 32'h0);
    step();

    // Backpressure: three ops, consumer stalled for four cycles.
    out_ready = 1'b0;
    set_op(OP, 3'b000, 7'b0, 5'd1, 32'd1, 32'd1, 32'h0, 32'h0);
    check("bp_rdy_a", {31'h0, in_ready}, 32'h1);
    step();
    set_op(OP, 3'b000, 7'b0, 5'd2, 32'd2, 32'd2, 32'h0, 32'h0);
    check("bp_rdy_b", {31'h0, in_ready}, 32'h1);
    step();
    set_op(OP, 3'b000, 7'b0, 5'd3, 32'd3, 32'd3, 32'h0, 32'h0);
    check("bp_rdy_drop", {31'h0, in_ready}, 32'h0);
    check("bp_hold_res", out_result, 32'd2);
    step();
    step();
    check("bp_stable_valid", {31'h0, out_valid}, 32'h1);
    check("bp_stable_res",   out_result, 32'd2);
    check("bp_stable_rd",    {27'h0, out_rd}, 32'd1);
    check("bp_still_low",    {31'h0, in_ready}, 32'h0);
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", {31'h0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    check("bp_second",    out_result, 32'd4);
    check("bp_second_rd", {27'h0, out_rd}, 32'd2);
    step();
    check("bp_third",    out_result, 32'd6);
    check("bp_third_rd", {27'h0, out_rd}, 32'd3);
    step();
    check("bp_empty", {31'h0, out_valid}, 32'h0);

    // Asynchronous reset with both stages full.
    set_op(OP, 3'b000, 7'b0, 5'd9, 32'd10, 32'd20, 32'h0, 32'h0);
    step();
    set_op(OP, 3'b110, 7'b0, 5'd9, 32'd10, 32'd20, 32'h0, 32'h0);
    step();
    in_valid = 1'b0;
    check("ar_pre_valid", {31'h0, out_valid}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", {31'h0, out_valid}, 32'h0);
    check("ar_in_ready",  {31'h0, in_ready}, 32'h1);
    check("ar_alu_op",    {28'h0, alu_operation}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ar_discarded", {31'h0, out_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
